// File: rtl/accu_alu_param_if.sv
// ---------------------------------------------------------------------------
// accu_alu_param_if
//   Command/result bundle for the accumulator ALU core.
//   master : command source (drives data_in, opcode, cin, load, ce)
//   slave  : ALU core       (drives cout, data_out, busy, done)
//   Signals:
//     data_in  [DATA_W]   load data
//     opcode   [SEL_W+4]  {sel, op}
//     cin                 carry/borrow/shift-in bit
//     load                write data_in to the selected register
//     ce                  command strobe
//     cout                registered carry/shift-out flag
//     data_out [DATA_W]   accumulator contents
//     busy                multi-cycle op in progress
//     done                one-cycle completion pulse
// ---------------------------------------------------------------------------
interface accu_alu_param_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
);
  logic [DATA_W-1:0]  data_in;
  logic [SEL_W+3:0]   opcode;
  logic               cin;
  logic               load;
  logic               ce;
  logic               cout;
  logic [DATA_W-1:0]  data_out;
  logic               busy;
  logic               done;

  modport master (
    output data_in, opcode, cin, load, ce,
    input  cout, data_out, busy, done
  );

  modport slave (
    input  data_in, opcode, cin, load, ce,
    output cout, data_out, busy, done
  );
endinterface

// File: rtl/accu_alu_param.sv
// ---------------------------------------------------------------------------
// accu_alu_param
//   Parametrised accumulator ALU core. One accumulator plus NREG general
//   registers; one command per strobed clock, result always lands in the
//   accumulator which drives data_out.
//   Optional feature macro: ALU_MUL_EN -- builds an unsigned shift-add
//   multiplier (op B) taking DATA_W cycles with a busy/done handshake.
//   Without it op B is a NOP and busy is tied low.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  accu_alu_param_if.slave (data_in, opcode, cin, load, ce in;
//          cout, data_out, busy, done out)
// ---------------------------------------------------------------------------
module accu_alu_param #(
  parameter int DATA_W = 8,
  parameter int NREG   = 7,
  parameter int SEL_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  accu_alu_param_if.slave    bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_LSH = 4'h2, OP_RSH = 4'h3,
    OP_XOR  = 4'h4, OP_CMP = 4'h5, OP_AND = 4'h6, OP_NAND = 4'h7,
    OP_OR   = 4'h8, OP_NOR = 4'h9, OP_CPY = 4'hA, OP_MUL  = 4'hB
  } op_e;

  logic [DATA_W-1:0] accu;
  logic [DATA_W-1:0] regs [NREG];
  logic              cout;
  logic              done;

  logic [SEL_W-1:0]  sel;
  logic [3:0]        op;
  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   alu_sum;
  logic [DATA_W:0]   alu_diff;
  logic [DATA_W-1:0] alu_accu;
  logic              alu_cout;
  logic              alu_wr;

  // Multiplier hooks; tied off when the multiplier is not built.
  logic              idle;
  logic              mul_issue;
  logic              mul_finish;
  logic [DATA_W-1:0] mul_lo;
  logic              mul_hi_nz;

  assign sel = bus.opcode[SEL_W+3:4];
  assign op  = bus.opcode[3:0];

  // Operand select: 0 is the accumulator, 1..NREG the register file,
  // anything above reads as zero.
  always_comb begin
    operand = '0;
    if (sel == '0) operand = accu;
    for (int i = 0; i < NREG; i++)
      if (int'(sel) == i + 1) operand = regs[i];
  end

  assign alu_sum  = {1'b0, accu} + {1'b0, operand} + {{DATA_W{1'b0}}, bus.cin};
  // Top bit of the (DATA_W+1)-bit difference is the borrow.
  assign alu_diff = {1'b0, accu} - {1'b0, operand} - {{DATA_W{1'b0}}, bus.cin};

  // NOTE: every output of a combinational block is given a default before the
  // case so that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    alu_accu = accu;
    alu_cout = 1'b0;
    alu_wr   = 1'b1;
    case (op)
      OP_ADD:  {alu_cout, alu_accu} = alu_sum;
      OP_SUB:  {alu_cout, alu_accu} = alu_diff;
      OP_LSH:  begin alu_accu = {accu[DATA_W-2:0], bus.cin}; alu_cout = accu[DATA_W-1]; end
      OP_RSH:  begin alu_accu = {bus.cin, accu[DATA_W-1:1]}; alu_cout = accu[0]; end
      OP_XOR:  alu_accu = accu ^ operand;
      OP_AND:  alu_accu = accu & operand;
      OP_NAND: alu_accu = ~(accu & operand);
      OP_OR:   alu_accu = accu | operand;
      OP_NOR:  alu_accu = ~(accu | operand);
      OP_CMP:  begin
        if (accu == operand)     alu_accu = DATA_W'(1);
        else if (accu > operand) alu_accu = DATA_W'(2);
        else                     alu_accu = DATA_W'(3);
      end
      OP_CPY:  alu_accu = operand;
      default: alu_wr = 1'b0;   // MUL handled separately; C..F are NOPs
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the register file is reset along with the accumulator because a
  // defined post-reset value is part of the block's contract.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accu <= '0;
      cout <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      if (mul_finish) begin
        accu <= mul_lo;
        cout <= mul_hi_nz;
        done <= 1'b1;
      end else if (idle && bus.ce) begin
        // A MUL issue completes later, so it does not pulse done here.
        done <= !mul_issue;
        if (bus.load) begin
          if (sel == '0) accu <= bus.data_in;
          for (int i = 0; i < NREG; i++)
            if (int'(sel) == i + 1) regs[i] <= bus.data_in;
        end else if (alu_wr) begin
          accu <= alu_accu;
          cout <= alu_cout;
        end
      end
    end
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {S_IDLE, S_MUL} state_e;
  state_e state, state_nxt;

  logic [2*DATA_W-1:0] prod, prod_next;
  logic [DATA_W-1:0]   mcand;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W:0]     psum;

  assign idle       = (state == S_IDLE);
  assign mul_issue  = idle && bus.ce && !bus.load && (op == OP_MUL);
  assign mul_finish = (state == S_MUL) && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (mul_issue)  state_nxt = S_MUL;
      S_MUL:  if (mul_finish) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One shift-add step: the multiplier sits in the low half and is consumed
  // LSB first while partial sums accumulate into the high half.
  assign psum      = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {psum, prod[DATA_W-1:1]};
  assign mul_lo    = prod_next[DATA_W-1:0];
  assign mul_hi_nz = |prod_next[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod  <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else if (mul_issue) begin
      mcand <= accu;
      prod  <= {{DATA_W{1'b0}}, operand};
      cnt   <= '0;
    end else if (state == S_MUL) begin
      prod  <= prod_next;
      cnt   <= cnt + 1'b1;
    end
  end

  assign bus.busy = (state == S_MUL);
`else
  assign idle       = 1'b1;
  assign mul_issue  = 1'b0;
  assign mul_finish = 1'b0;
  assign mul_lo     = '0;
  assign mul_hi_nz  = 1'b0;
  assign bus.busy   = 1'b0;
`endif

  assign bus.data_out = accu;
  assign bus.cout     = cout;
  assign bus.done     = done;

endmodule

// File: tb/tb_accu_alu_param.sv
// ---------------------------------------------------------------------------
// tb_accu_alu_param
//   Self-checking bench for accu_alu_param (DATA_W=8, NREG=7). Directed
//   vectors followed by random commands, each compared against an
//   integer-arithmetic reference model. Honours ALU_MUL_EN like the design.
// ---------------------------------------------------------------------------
module tb_accu_alu_param;
  localparam int W     = 8;
  localparam int NREG  = 7;
  localparam int SEL_W = 3;
  localparam int MASK  = (1 << W) - 1;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  // Reference model state.
  int m_accu;
  int m_cout;
  int m_regs [NREG];

  accu_alu_param_if #(.DATA_W(W), .SEL_W(SEL_W)) bus ();

  accu_alu_param #(.DATA_W(W), .NREG(NREG), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int exp_done);
    check({tag, ".data_out"}, 32'(bus.data_out), 32'(m_accu));
    check({tag, ".cout"},     32'(bus.cout),     32'(m_cout));
    check({tag, ".busy"},     32'(bus.busy),     32'd0);
    check({tag, ".done"},     32'(bus.done),     32'(exp_done));
  endtask

  task automatic model_reset();
    m_accu = 0;
    m_cout = 0;
    for (int i = 0; i < NREG; i++) m_regs[i] = 0;
  endtask

  // Behavioural reference: returns 1 when the command is a multi-cycle MUL.
  function automatic int model_apply(input int sel, input int op, input int ld,
                                     input int din, input int cin);
    int r, t;
    r = (sel == 0) ? m_accu : (sel <= NREG) ? m_regs[sel-1] : 0;
    if (ld != 0) begin
      if (sel == 0) m_accu = din;
      else if (sel <= NREG) m_regs[sel-1] = din;
      return 0;
    end
    case (op)
      0:  begin t = m_accu + r + cin; m_accu = t & MASK; m_cout = (t > MASK) ? 1 : 0; end
      1:  begin t = m_accu - r - cin; m_accu = t & MASK; m_cout = (t < 0) ? 1 : 0; end
      2:  begin m_cout = (m_accu >> (W-1)) & 1; m_accu = ((m_accu << 1) | cin) & MASK; end
      3:  begin m_cout = m_accu & 1; m_accu = (cin << (W-1)) | (m_accu >> 1); end
      4:  begin m_accu = m_accu ^ r;             m_cout = 0; end
      5:  begin m_accu = (m_accu == r) ? 1 : (m_accu > r) ? 2 : 3; m_cout = 0; end
      6:  begin m_accu = m_accu & r;             m_cout = 0; end
      7:  begin m_accu = ~(m_accu & r) & MASK;   m_cout = 0; end
      8:  begin m_accu = m_accu | r;             m_cout = 0; end
      9:  begin m_accu = ~(m_accu | r) & MASK;   m_cout = 0; end
      10: begin m_accu = r;                      m_cout = 0; end
`ifdef ALU_MUL_EN
      11: begin t = m_accu * r; m_accu = t & MASK; m_cout = ((t >> W) != 0) ? 1 : 0; return 1; end
`endif
      default: ;
    endcase
    return 0;
  endfunction

  task automatic drive(input int sel, input int op, input int ld, input int din, input int cin);
    bus.opcode  = {SEL_W'(sel), 4'(op)};
    bus.load    = ld[0];
    bus.data_in = W'(din);
    bus.cin     = cin[0];
    bus.ce      = 1'b1;
  endtask

  // Starts and ends at a falling edge; outputs are checked there.
  task automatic cmd(input string tag, input int sel, input int op, input int ld,
                     input int din, input int cin);
    int is_mul, n;
    is_mul = model_apply(sel, op, ld, din, cin);
    drive(sel, op, ld, din, cin);
    @(negedge clk);
    bus.ce = 1'b0;
    if (is_mul != 0) begin
      n = 0;
      while (bus.busy === 1'b1 && n < 3 * W) begin
        @(negedge clk);
        n++;
      end
      check({tag, ".mul_cycles"}, 32'(n), 32'(W));
    end
    check_outputs(tag, 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.data_in = '0;
    bus.opcode  = '0;
    bus.cin     = 1'b0;
    bus.load    = 1'b0;
    bus.ce      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs("reset", 0);

    // Loads and readback.
    cmd("ld_accu", 0, 0, 1, 'h01, 0);
    cmd("ld_r0",   1, 0, 1, 'h02, 0);
    cmd("ld_r1",   2, 0, 1, 'hAA, 0);
    cmd("ld_r2",   3, 0, 1, 'h0F, 0);
    cmd("cpy_r0",  1, 10, 0, 0, 0);
    check("cpy_r0.lit", 32'(bus.data_out), 32'h02);
    cmd("cpy_r1",  2, 10, 0, 0, 0);
    check("cpy_r1.lit", 32'(bus.data_out), 32'hAA);
    cmd("cpy_r2",  3, 10, 0, 0, 0);
    check("cpy_r2.lit", 32'(bus.data_out), 32'h0F);

    // ADD with carry-in, and full carry-out boundary.
    cmd("ld_a01", 0, 0, 1, 'h01, 0);
    cmd("add_r0", 1, 0, 0, 0, 1);
    check("add_r0.lit", 32'(bus.data_out), 32'h04);
    cmd("ld_aff", 0, 0, 1, 'hFF, 0);
    cmd("add_aa", 0, 0, 0, 0, 1);
    check("add_aa.lit", 32'(bus.data_out), 32'hFF);
    check("add_aa.cout", 32'(bus.cout), 32'd1);

    // Shifts.
    cmd("ld_a0d", 0, 0, 1, 'h0D, 0);
    cmd("lsh",    0, 2, 0, 0, 1);
    check("lsh.lit", 32'(bus.data_out), 32'h1B);
    cmd("rsh",    0, 3, 0, 0, 0);
    check("rsh.lit", 32'(bus.data_out), 32'h0D);
    check("rsh.cout", 32'(bus.cout), 32'd1);

    // Compare in all three outcomes, NOR, borrow.
    cmd("ld_r3",  4, 0, 1, 'h04, 0);
    cmd("ld_a05", 0, 0, 1, 'h05, 0);
    cmd("cmp_gt", 4, 5, 0, 0, 0);
    check("cmp_gt.lit", 32'(bus.data_out), 32'h02);
    cmd("ld_a04", 0, 0, 1, 'h04, 0);
    cmd("cmp_eq", 4, 5, 0, 0, 0);
    check("cmp_eq.lit", 32'(bus.data_out), 32'h01);
    cmd("ld_a03", 0, 0, 1, 'h03, 0);
    cmd("cmp_lt", 4, 5, 0, 0, 0);
    check("cmp_lt.lit", 32'(bus.data_out), 32'h03);
    cmd("ld_aaa", 0, 0, 1, 'hAA, 0);
    cmd("nor_r2", 3, 9, 0, 0, 0);
    check("nor_r2.lit", 32'(bus.data_out), 32'h50);
    cmd("ld_a03b", 0, 0, 1, 'h03, 0);
    cmd("sub_brw", 4, 1, 0, 0, 0);
    check("sub_brw.cout", 32'(bus.cout), 32'd1);

    // ce low: nothing changes, no done pulse.
    drive(0, 0, 1, 'h77, 1);
    bus.ce = 1'b0;
    @(negedge clk);
    check_outputs("ce_low", 0);

    cmd("nop_c", 2, 12, 0, 0, 1);
    cmd("nop_f", 0, 15, 0, 0, 0);

`ifdef ALU_MUL_EN
    // MUL with an ADD strobed mid-operation that must be ignored.
    cmd("ld_r5",  6, 0, 1, 'h20, 0);
    cmd("ld_a10", 0, 0, 1, 'h10, 0);
    void'(model_apply(6, 11, 0, 0, 0));
    drive(6, 11, 0, 0, 0);
    @(negedge clk);
    bus.ce = 1'b0;
    check("mul.busy0", 32'(bus.busy), 32'd1);
    check("mul.done0", 32'(bus.done), 32'd0);
    for (int k = 1; k <= W; k++) begin
      if (k <= 3) drive(1, 0, 0, 0, 1);
      else        bus.ce = 1'b0;
      @(negedge clk);
      check($sformatf("mul.busy%0d", k), 32'(bus.busy), 32'(k < W));
      check($sformatf("mul.done%0d", k), 32'(bus.done), 32'(k == W));
    end
    bus.ce = 1'b0;
    check("mul.lit", 32'(bus.data_out), 32'h00);
    check("mul.cout", 32'(bus.cout), 32'd1);
    cmd("add_after", 1, 0, 0, 0, 0);
    check("add_after.lit", 32'(bus.data_out), 32'h02);
    cmd("mul_small", 1, 11, 0, 0, 0);

    // Reset during the 4th MUL cycle.
    drive(2, 11, 0, 0, 0);
    @(negedge clk);
    bus.ce = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_mid", 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs("rst_rel", 0);
    cmd("post_rst_cpy", 2, 10, 0, 0, 0);
    cmd("post_rst_ld",  0, 0, 1, 'h33, 0);
`else
    // Without the multiplier op B behaves as a NOP.
    cmd("ld_a10", 0, 0, 1, 'h10, 0);
    cmd("opb_nop", 1, 11, 0, 0, 0);
    check("opb_nop.lit", 32'(bus.data_out), 32'h10);
`endif

    // Random commands against the model.
    for (int i = 0; i < 300; i++) begin
      int sel, op, ld, din, cin;
      sel = int'($urandom_range(0, (1 << SEL_W) - 1));
      op  = int'($urandom_range(0, 15));
      ld  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      din = int'($urandom_range(0, MASK));
      cin = int'($urandom_range(0, 1));
      cmd($sformatf("rnd%0d", i), sel, op, ld, din, cin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
